// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access formatter in front of the data memory.
// Port 0 is the core load/store unit and port 1 is the DMA/loader. Grants are
// combinational. Responses are registered and arrive one cycle after the grant.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   req_i/we_i/size_i/uns_i      per-port request and its attributes
//   addr_i/wdata_i               per-port byte address and right-justified store data
//   gnt_o                        per-port combinational grant
//   rvalid_o/err_o/rdata_o       per-port response (valid, error, formatted load data)
//   mem_read_o/mem_write_o       memory strobes (combinational, follow the grant)
//   mem_byte_en_o/mem_addr_o     lane enables and word-aligned address
//   mem_wdata_o/mem_rdata_i      lane-replicated store data and combinational read data
module dmem_arbiter #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_i,
  input  logic [1:0]       we_i,
  input  logic [1:0][1:0]  size_i,
  input  logic [1:0]       uns_i,
  input  logic [1:0][31:0] addr_i,
  input  logic [1:0][31:0] wdata_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       rvalid_o,
  output logic [1:0][31:0] rdata_o,
  output logic [1:0]       err_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic [3:0]       mem_byte_en_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  localparam int unsigned NP  = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);
  localparam logic [DW-1:0]  MAX_ADDR = DW'(MEM_DEPTH * 4 - 1);

  // state
  logic                     last_winner_q, last_winner_d;
  logic [NP-1:0][WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_port_q, resp_port_d;
  logic                     resp_err_q, resp_err_d;
  logic [DW-1:0]            resp_data_q, resp_data_d;

  // arbitration and access decode
  logic [NP-1:0]            gnt_c;
  logic                     any_gnt;
  logic                     sel;
  logic                     s_we, s_uns;
  logic [1:0]               s_size;
  logic [DW-1:0]            s_addr, s_wdata;
  logic                     acc_err, acc_ok;
  logic [3:0]               be_c;
  logic [DW-1:0]            wrep_c, shifted_c, load_c;

  // Arbitration: starvation override first, then round-robin on contention.
  always_comb begin
    any_gnt = 1'b0;
    sel     = 1'b0;
    if (!rst && (req_i != '0)) begin
      any_gnt = 1'b1;
      if (req_i[0] && (wait_cnt_q[0] == WAIT_SAT)) begin
        sel = 1'b0;
      end else if (req_i[1] && (wait_cnt_q[1] == WAIT_SAT)) begin
        sel = 1'b1;
      end else if (req_i == 2'b11) begin
        sel = ~last_winner_q;
      end else begin
        sel = req_i[1];
      end
    end
    gnt_c = '0;
    if (any_gnt) gnt_c[sel] = 1'b1;
  end

  assign gnt_o = gnt_c;

  // Selected request attributes.
  always_comb begin
    s_we    = we_i[sel];
    s_uns   = uns_i[sel];
    s_size  = size_i[sel];
    s_addr  = addr_i[sel];
    s_wdata = wdata_i[sel];
  end

  // Alignment, size legality and range checks on the granted request.
  always_comb begin
    acc_err = 1'b0;
    if (s_size == 2'b11)                             acc_err = 1'b1;
    if ((s_size == 2'b01) && s_addr[0])              acc_err = 1'b1;
    if ((s_size == 2'b10) && (s_addr[1:0] != 2'b00)) acc_err = 1'b1;
    if (s_addr > MAX_ADDR)                           acc_err = 1'b1;
    acc_err = acc_err && any_gnt;
    acc_ok  = any_gnt && !acc_err;
  end

  // Lane enables, store-data replication and load alignment/extension.
  always_comb begin
    be_c      = 4'b1111;
    wrep_c    = s_wdata;
    shifted_c = mem_rdata_i >> {s_addr[1:0], 3'b000};
    load_c    = shifted_c;
    case (s_size)
      2'b00: begin
        be_c   = 4'b0001 << s_addr[1:0];
        wrep_c = {4{s_wdata[7:0]}};
        load_c = s_uns ? {24'd0, shifted_c[7:0]} : {{24{shifted_c[7]}}, shifted_c[7:0]};
      end
      2'b01: begin
        be_c   = 4'b0011 << s_addr[1:0];
        wrep_c = {2{s_wdata[15:0]}};
        load_c = s_uns ? {16'd0, shifted_c[15:0]} : {{16{shifted_c[15]}}, shifted_c[15:0]};
      end
      default: ;
    endcase
  end

  // Memory port: everything zero when idle or when the granted access errors.
  always_comb begin
    mem_read_o    = acc_ok && !s_we;
    mem_write_o   = acc_ok && s_we;
    mem_byte_en_o = acc_ok ? be_c : 4'b0000;
    mem_addr_o    = acc_ok ? {s_addr[DW-1:2], 2'b00} : '0;
    mem_wdata_o   = (acc_ok && s_we) ? wrep_c : '0;
  end

  // Next-state for arbitration history and the response stage.
  always_comb begin
    last_winner_d = any_gnt ? sel : last_winner_q;
    for (int p = 0; p < NP; p++) begin
      wait_cnt_d[p] = '0;
      if (req_i[p] && !gnt_c[p]) begin
        wait_cnt_d[p] = (wait_cnt_q[p] == WAIT_SAT) ? WAIT_SAT : wait_cnt_q[p] + WCW'(1);
      end
    end
    resp_valid_d = any_gnt;
    resp_port_d  = sel;
    resp_err_d   = acc_err;
    resp_data_d  = (acc_ok && !s_we) ? load_c : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner_q <= 1'b1;
      wait_cnt_q    <= '0;
      resp_valid_q  <= 1'b0;
      resp_port_q   <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      last_winner_q <= last_winner_d;
      wait_cnt_q    <= wait_cnt_d;
      resp_valid_q  <= resp_valid_d;
      resp_port_q   <= resp_port_d;
      resp_err_q    <= resp_err_d;
      resp_data_q   <= resp_data_d;
    end
  end

  // Per-port response steering; reset masks a response already in flight.
  always_comb begin
    logic rv;
    for (int p = 0; p < NP; p++) begin
      rv          = !rst && resp_valid_q && (resp_port_q == 1'(p));
      rvalid_o[p] = rv;
      err_o[p]    = rv && resp_err_q;
      rdata_o[p]  = rv ? resp_data_q : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed test-plan cases plus randomized two-port traffic,
// all checked against a byte-level behavioural model of the memory and arbitration.
module tb_dmem_arbiter;

  localparam int unsigned MEM_DEPTH = 1024;
  localparam int unsigned MAX_WAIT  = 2;
  localparam int unsigned NBYTES    = MEM_DEPTH * 4;
  localparam int unsigned IDXW      = $clog2(MEM_DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = '0, we = '0, uns = '0;
  logic [1:0][1:0]  size = '0;
  logic [1:0][31:0] addr = '0, wdata = '0;
  logic [1:0]       gnt, rvalid, err;
  logic [1:0][31:0] rdata;
  logic             mem_read, mem_write;
  logic [3:0]       mem_be;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_DEPTH(MEM_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .we_i(we), .size_i(size), .uns_i(uns), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_byte_en_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Memory device driven by the DUT's strobes.
  logic [31:0] dev_mem [MEM_DEPTH];
  logic        mem_init_done = 1'b0;
  assign mem_rdata = dev_mem[mem_addr[IDXW+1:2]];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) dev_mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dev_mem[mem_addr[IDXW+1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: byte-addressed memory image, arbitration history, one pending response.
  logic [7:0]  ref_mem [NBYTES];
  int          m_last;
  int          m_wait [2];
  logic [1:0]  exp_v, exp_e;
  logic [31:0] exp_d [2];

  initial begin
    int w, n;
    logic [31:0] a, val, ewd;
    logic [3:0]  ebe;
    logic [1:0]  eg;
    bit          bad;
    logic [1:0]  nv, ne;
    logic [31:0] nd [2];
    for (int i = 0; i < int'(MEM_DEPTH); i++)
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = init_word(i) >> (8*b);
    m_last = 1; m_wait[0] = 0; m_wait[1] = 0; exp_v = '0; exp_e = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata0", rdata[0], 32'd0);
        chk("rst_rdata1", rdata[1], 32'd0);
        chk("rst_strobes", {26'd0, mem_read, mem_write, mem_be}, 32'd0);
        m_last = 1; m_wait[0] = 0; m_wait[1] = 0; exp_v = '0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("rvalid%0d", p), 32'(rvalid[p]), 32'(exp_v[p]));
          if (exp_v[p]) begin
            chk($sformatf("err%0d", p), 32'(err[p]), 32'(exp_e[p]));
            chk($sformatf("rdata%0d", p), rdata[p], exp_d[p]);
          end
        end
        w = -1;
        if (req == 2'b11) begin
          if (m_wait[0] >= int'(MAX_WAIT))      w = 0;
          else if (m_wait[1] >= int'(MAX_WAIT)) w = 1;
          else                                  w = 1 - m_last;
        end else if (req[0]) w = 0;
        else if (req[1])     w = 1;
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        for (int p = 0; p < 2; p++) begin
          if (req[p] && w != p) m_wait[p] = (m_wait[p] + 1 > int'(MAX_WAIT)) ? int'(MAX_WAIT) : m_wait[p] + 1;
          else                  m_wait[p] = 0;
        end
        if (w >= 0) m_last = w;
        nv = '0; ne = '0; nd[0] = '0; nd[1] = '0;
        bad = 1'b1;
        if (w >= 0) begin
          a = addr[w];
          n = 1 << size[w];
          bad = (size[w] == 2'b11) || (a % 32'(n) != 0) || (a >= NBYTES);
          nv[w] = 1'b1;
          ne[w] = bad;
        end
        if (bad) begin
          chk("idle_strobes", {26'd0, mem_read, mem_write, mem_be}, 32'd0);
          chk("idle_addr", mem_addr, 32'd0);
          chk("idle_wdata", mem_wdata, 32'd0);
        end else begin
          ebe = '0;
          for (int k = 0; k < n; k++) ebe[(a % 4) + k] = 1'b1;
          chk("mem_read", 32'(mem_read), 32'(!we[w]));
          chk("mem_write", 32'(mem_write), 32'(we[w]));
          chk("mem_be", 32'(mem_be), 32'(ebe));
          chk("mem_addr", mem_addr, a - (a % 4));
          if (we[w]) begin
            for (int l = 0; l < 4; l++) ewd[8*l +: 8] = wdata[w][8*(l % n) +: 8];
            chk("mem_wdata", mem_wdata, ewd);
            for (int k = 0; k < n; k++) ref_mem[a + k] = wdata[w][8*k +: 8];
          end else begin
            val = '0;
            for (int k = 0; k < n; k++) val = val | (32'(ref_mem[a + k]) << (8*k));
            if (n < 4 && !uns[w] && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
            nd[w] = val;
          end
        end
        exp_v = nv; exp_e = ne; exp_d[0] = nd[0]; exp_d[1] = nd[1];
      end
    end
  end

  // Single-port directed access; returns the response and the strobes seen at grant.
  task automatic do_op(input string nm, input int p, input bit w, input logic [1:0] sz,
                       input bit u, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e, output logic [3:0] gbe,
                       output logic [31:0] gwd, output logic [1:0] gstb);
    bit got;
    @(posedge clk); #1;
    we[p] = w; size[p] = sz; uns[p] = u; addr[p] = a; wdata[p] = wd; req[p] = 1'b1;
    got = 1'b0; gbe = '0; gwd = '0; gstb = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt[p]) begin
        got = 1'b1; gbe = mem_be; gwd = mem_wdata; gstb = {mem_read, mem_write};
        break;
      end
    end
    chk({nm, "_gnt"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    req[p] = 1'b0;
    @(negedge clk);
    chk({nm, "_rvalid"}, 32'(rvalid[p]), 32'd1);
    rd = rdata[p]; e = err[p];
  endtask

  task automatic gen(input int p);
    logic [1:0]  sz;
    logic [31:0] a;
    if ($urandom_range(0, 3) == 0) begin
      req[p] = 1'b0;
    end else begin
      req[p]   = 1'b1;
      we[p]    = 1'($urandom_range(0, 1));
      uns[p]   = 1'($urandom_range(0, 1));
      sz       = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a        = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(0, NBYTES - 1));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 19) == 0) a = ($urandom_range(0, 1) == 0) ? NBYTES + 32'($urandom_range(0, 15)) : $urandom;
      size[p]  = sz;
      addr[p]  = a;
      wdata[p] = $urandom;
    end
  endtask

  initial begin
    logic [31:0] rd, gwd;
    logic        e;
    logic [3:0]  gbe;
    logic [1:0]  gstb, g;
    logic [1:0]  gseq [6];
    logic [1:0]  rseq [6];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Byte store then signed/unsigned byte loads.
    do_op("st_b", 0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, rd, e, gbe, gwd, gstb);
    chk("st_b_be", 32'(gbe), 32'h8);
    chk("st_b_wdata", gwd, 32'hA5A5_A5A5);
    chk("st_b_err", 32'(e), 32'd0);
    do_op("ld_bs", 0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, rd, e, gbe, gwd, gstb);
    chk("ld_bs_data", rd, 32'hFFFF_FFA5);
    do_op("ld_bu", 0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, rd, e, gbe, gwd, gstb);
    chk("ld_bu_data", rd, 32'h0000_00A5);

    // Half loads from a word written by the DMA port.
    do_op("st_w", 1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h8001_7F02, rd, e, gbe, gwd, gstb);
    chk("st_w_be", 32'(gbe), 32'hF);
    do_op("ld_hs", 0, 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, rd, e, gbe, gwd, gstb);
    chk("ld_hs_data", rd, 32'hFFFF_8001);
    do_op("ld_hu", 0, 1'b0, 2'b01, 1'b1, 32'h40, 32'h0, rd, e, gbe, gwd, gstb);
    chk("ld_hu_data", rd, 32'h0000_7F02);

    // Rejected accesses: misaligned, illegal size, out of range.
    do_op("e_mis", 0, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, rd, e, gbe, gwd, gstb);
    chk("e_mis_err", 32'(e), 32'd1);
    chk("e_mis_data", rd, 32'd0);
    chk("e_mis_strobe", 32'(gstb), 32'd0);
    do_op("e_size", 1, 1'b1, 2'b11, 1'b0, 32'h40, 32'hDEAD_BEEF, rd, e, gbe, gwd, gstb);
    chk("e_size_err", 32'(e), 32'd1);
    chk("e_size_strobe", 32'(gstb), 32'd0);
    do_op("e_oor", 0, 1'b1, 2'b10, 1'b0, NBYTES, 32'h1234_5678, rd, e, gbe, gwd, gstb);
    chk("e_oor_err", 32'(e), 32'd1);
    chk("e_oor_strobe", 32'(gstb), 32'd0);
    do_op("ld_w", 0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, e, gbe, gwd, gstb);
    chk("ld_w_unchanged", rd, 32'h8001_7F02);

    // Continuous contention straight out of reset: 0,1,0,1 with responses trailing by one.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    we = '0; size[0] = 2'b10; size[1] = 2'b00; addr[0] = 32'h40; addr[1] = 32'h103; uns = '0;
    req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      gseq[k] = gnt; rseq[k] = rvalid;
    end
    @(posedge clk); #1 req = '0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("cont_gnt%0d", k), 32'(gseq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("cont_rv%0d", k), 32'(rseq[k]), (k == 0) ? 32'd0 : ((k % 2 == 1) ? 32'd1 : 32'd2));
    end

    // Reset in the cycle after a load grant drops the response.
    @(posedge clk); #1;
    we[0] = 1'b0; size[0] = 2'b10; addr[0] = 32'h40; req = 2'b01;
    @(negedge clk);
    chk("rr_gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1 req = '0; rst = 1'b1;
    @(negedge clk);
    chk("rr_rvalid", 32'(rvalid), 32'd0);
    chk("rr_rdata", rdata[0], 32'd0);
    @(posedge clk); #1 rst = 1'b0; req = 2'b11;
    @(negedge clk);
    chk("rr_first_gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1 req = '0;

    // Randomized traffic with request hold and occasional reset pulses.
    g = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < 2; p++) if (g[p] || !req[p]) gen(p);
      @(negedge clk);
      g = gnt;
    end
    @(posedge clk); #1 req = '0; rst = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access controller in front of the byte-addressed data memory. Shares the single memory port between the core load/store unit (port 0) and the DMA/loader port (port 1), then formats each granted access. Formatting covers size decoding into byte enables, store-data lane placement, load-data alignment with sign or zero extension, and alignment and range checking. Responses come back on a registered, one-cycle-latency response channel per port.

## Interface
Parameters:
- MEM_DEPTH, 1024, memory size in 32-bit words; valid byte addresses are 0 .. MEM_DEPTH*4-1.
- MAX_WAIT, 4, consecutive cycles a requesting port may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_i[p]  in  1  request from port p (p = 0 core, p = 1 DMA).
- we_i[p]  in  1  1 = store, 0 = load.
- size_i[p]  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- uns_i[p]  in  1  load zero-extend when 1, sign-extend when 0.
- addr_i[p]  in  32  byte address.
- wdata_i[p]  in  32  store data, right-justified.
- gnt_o[p]  out  1  request accepted this cycle (combinational).
- rvalid_o[p]  out  1  response valid, one cycle after the grant.
- rdata_o[p]  out  32  formatted load data; 0 for stores and errors.
- err_o[p]  out  1  qualifies rvalid_o; access was rejected.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- mem_byte_en_o  out  4  memory byte enables.
- mem_addr_o  out  32  word-aligned address, addr & ~3.
- mem_wdata_o  out  32  lane-shifted store data.
- mem_rdata_i  in  32  combinational read data from memory.

## Operation
- **Request hold:** a requester holds req and all attributes stable until gnt. Grant is decided combinationally in the same cycle.
- **Arbitration:**
  - Single request: that port is granted.
  - Both requesting: round-robin on a 1-bit last_winner register. The port that did not win last wins now.
  - Starvation override: wait_cnt[p] counts consecutive cycles with req_i[p]=1 and gnt_o[p]=0, saturating at MAX_WAIT. A port at MAX_WAIT wins unconditionally; if both are at MAX_WAIT, port 0 wins.
  - wait_cnt[p] clears on grant, or on any cycle where req_i[p]=0.
  - last_winner updates only on cycles that issue a grant.
- **Checks on the granted request:**
  - misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
  - illegal: size=11.
  - out of range: addr > MEM_DEPTH*4-1.
  - Any failure: grant is still given, mem_read_o = mem_write_o = 0, response has err=1 and rdata=0.
- **Byte enables:** byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
- **Store path:** mem_wdata_o = wdata replicated (byte to all 4 lanes, half to both halves, word unchanged). mem_write_o = we; mem_read_o = 0.
- **Load path:** mem_read_o=1; mem_rdata_i is captured at the grant edge.
  - Shift right by 8*addr[1:0].
  - Extend from bit 7 (byte) or bit 15 (half) per uns_i.
- **Idle memory port:** when nothing is granted, or the grant is erroring, drive mem_read_o, mem_write_o and mem_byte_en_o to 0. mem_addr_o and mem_wdata_o are don't-care but must be deterministic; drive 0.
- **Response stage registers:** the granted port index, err, and the formatted load data.

## Timing
- **Grant:** same cycle as request, combinational. At most one gnt_o high per cycle.
- **Response:** rvalid_o[p] pulses for exactly one cycle, the cycle after gnt_o[p]. Back-to-back grants give back-to-back responses; throughput is 1 access/cycle.
- **Store visibility:** a store granted in cycle N is visible to a load granted in cycle N+1.
- **Reset values:** rvalid_o=0, err_o=0, rdata_o=0, last_winner=1 (so port 0 wins the first contention), wait_cnt=0, all mem strobes 0.
- **Reset mid-operation:** rst high in the cycle after a grant suppresses that response (rvalid_o stays 0). While rst=1, gnt_o=0 and no memory strobes are issued.
- **Unrequested rvalid:** rvalid_o must never assert for a port that was not granted in the previous cycle.

## Test plan
- **Store/load byte:** port 0 stores byte 0xA5 at 0x103, then loads signed byte at 0x103. Required: byte_en=1000, wdata=0xA5A5A5A5, response rdata=0xFFFFFFA5 one cycle after grant; the unsigned load gives 0x000000A5.
- **Half load:** memory word 0x8001_7F02 at 0x40; half load at 0x42 signed -> 0xFFFF8001; at 0x40 unsigned -> 0x00007F02.
- **Contention:** both ports request continuously from reset. Required grant order 0,1,0,1…; each rvalid_o follows its own grant by one cycle.
- **Starvation:** MAX_WAIT=2; port 1 requests continuously while port 0 requests continuously. Check the wait counter never exceeds 2 and port 1 is granted no later than the third contended cycle.
- **Errors:** word load at 0x6, size=11, and addr=MEM_DEPTH*4. Each gets a grant, no mem strobe, err_o=1, rdata_o=0, and memory contents unchanged.
- **Reset during response:** rst asserted in the cycle after a load grant. Required: no rvalid_o; outputs at reset values; next request after rst falls is granted to port 0.
